// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with scoreboard.
//   NUM_RD combinational read ports, two prioritised write ports (port 1 wins),
//   per-register busy bit for RAW hazard detection. Register 0 reads 0 and is
//   never busy.
// Optional feature: define REG_FILE_BYPASS_EN for same-cycle write-to-read
//   forwarding (data and busy).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_rd_addr / o_rd_data    packed read addresses / read data
//   o_rd_busy                busy bit of each addressed register
//   i_we0/i_wa0/i_wd0        write port 0
//   i_we1/i_wa1/i_wd1        write port 1 (higher priority)
//   i_alloc_en/i_alloc_addr  mark a destination register busy
//   o_busy_vec               full scoreboard
//   o_wr_conflict            pulse: both ports wrote the same nonzero register
module reg_file_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     i_rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     o_rd_data,
  output logic [NUM_RD-1:0]                o_rd_busy,
  input  logic                             i_we0,
  input  logic [ADDR_WIDTH-1:0]            i_wa0,
  input  logic [DATA_WIDTH-1:0]            i_wd0,
  input  logic                             i_we1,
  input  logic [ADDR_WIDTH-1:0]            i_wa1,
  input  logic [DATA_WIDTH-1:0]            i_wd1,
  input  logic                             i_alloc_en,
  input  logic [ADDR_WIDTH-1:0]            i_alloc_addr,
  output logic [(2**ADDR_WIDTH)-1:0]       o_busy_vec,
  output logic                             o_wr_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic                  wr_conflict;

  // Qualified write strobes: register 0 is never written
  logic wr0_c, wr1_c, conflict_c;
  assign wr1_c      = i_we1 && (i_wa1 != '0);
  assign conflict_c = i_we0 && wr1_c && (i_wa0 == i_wa1);
  assign wr0_c      = i_we0 && (i_wa0 != '0) && !conflict_c;

  // Scoreboard update: writes retire producers, a new alloc wins over a write
  always_comb begin
    busy_next = busy;
    if (i_we0) busy_next[i_wa0] = 1'b0;
    if (i_we1) busy_next[i_wa1] = 1'b0;
    if (i_alloc_en) busy_next[i_alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wr0_c) regs[i_wa0] <= i_wd0;
      if (wr1_c) regs[i_wa1] <= i_wd1;
      busy        <= busy_next;
      wr_conflict <= conflict_c;
    end
  end

  // Combinational read ports
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra        = '0;
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (ra != '0) begin
        o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
        o_rd_busy[k]                          = busy[ra];
`ifdef REG_FILE_BYPASS_EN
        // Forward in-flight write data; port 1 checked last so it wins
        if (i_we0 && (i_wa0 == ra)) begin
          o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = i_wd0;
          o_rd_busy[k] = i_alloc_en && (i_alloc_addr == ra);
        end
        if (i_we1 && (i_wa1 == ra)) begin
          o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = i_wd1;
          o_rd_busy[k] = i_alloc_en && (i_alloc_addr == ra);
        end
`endif
      end
    end
  end

  assign o_busy_vec    = busy;
  assign o_wr_conflict = wr_conflict;

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb (NUM_RD=4): directed steps then randomized cycles
// checked against an array-based reference model.
module tb_reg_file_sb;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NR    = 4;
  localparam int unsigned DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              we0, we1, alloc_en;
  logic [AW-1:0]     wa0, wa1, alloc_addr;
  logic [DW-1:0]     wd0, wd1;
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_conflict;

  always #5 clk = ~clk;

  reg_file_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_we0        (we0),
    .i_wa0        (wa0),
    .i_wd0        (wd0),
    .i_we1        (we1),
    .i_wa1        (wa1),
    .i_wd1        (wd1),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_busy_vec   (busy_vec),
    .o_wr_conflict(wr_conflict)
  );

  // Reference model state
  logic [DW-1:0]    mreg [DEPTH];
  logic [DEPTH-1:0] mbusy;
  logic             mconf;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if ((we0 && wa0 == a) || (we1 && wa1 == a)) return alloc_en && alloc_addr == a;
`endif
    return mbusy[a];
  endfunction

  task automatic check_reads(input string tag);
    logic [NR*DW-1:0] ed;
    logic [NR-1:0]    eb;
    logic [AW-1:0]    a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      ed[k*DW +: DW] = exp_data(a);
      eb[k]          = exp_busy(a);
    end
    chk({tag, "_rdata"}, 128'(rd_data), 128'(ed));
    chk({tag, "_rbusy"}, 128'(rd_busy), 128'(eb));
  endtask

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
      mbusy = '0;
      mconf = 1'b0;
    end else begin
      mconf = we0 && we1 && (wa0 == wa1) && (wa0 != 0);
      if (we0 && wa0 != 0) mreg[wa0] = wd0;
      if (we1 && wa1 != 0) mreg[wa1] = wd1;
      if (we0) mbusy[wa0] = 1'b0;
      if (we1) mbusy[wa1] = 1'b0;
      if (alloc_en) mbusy[alloc_addr] = 1'b1;
      mbusy[0] = 1'b0;
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at next posedge+1
  task automatic tick(input string tag);
    #1 check_reads({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_reads({tag, "_post"});
    chk({tag, "_busyvec"}, 128'(busy_vec), 128'(mbusy));
    chk({tag, "_conflict"}, 128'(wr_conflict), 128'(mconf));
  endtask

  task automatic idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; alloc_addr = '0;
  endtask

  function automatic logic [NR*AW-1:0] raddr(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
    mbusy = '0;
    mconf = 1'b0;
    idle();
    rd_addr = '0;
    @(posedge clk); #1;

    // Initial reset
    rst = 1'b1;
    tick("reset0");
    chk("reset0_busy_zero", 128'(busy_vec), 128'(0));
    idle();

    // Preload every register nonzero and mark some busy
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = $urandom | 32'h1;
      alloc_en = 1'b1; alloc_addr = 5'(DEPTH - i);
      rd_addr = raddr(i, i - 1, 1, 2);
      tick("preload");
    end
    // Reset overrides concurrent writes and alloc
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    rst = 1'b1;
    tick("reset_mid");
    idle();
    for (int g = 0; g < DEPTH / NR; g++) begin
      rd_addr = raddr(4*g + 3, 4*g + 2, 4*g + 1, 4*g);
      tick("rst_read");
      chk("rst_zero_data", 128'(rd_data), 128'(0));
    end
    chk("rst_zero_busy", 128'(busy_vec), 128'(0));
    chk("rst_zero_conflict", 128'(wr_conflict), 128'(0));

    // Writes to register 0 are ignored
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick("r0_write");
    idle();
    rd_addr = raddr(0, 0, 0, 0);
    tick("r0_read");
    chk("r0_data", 128'(rd_data), 128'(0));
    chk("r0_busy", 128'(busy_vec[0]), 128'(0));

    // Same-address write conflict: port 1 wins, one-cycle pulse
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    rd_addr = raddr(0, 0, 0, 5);
    tick("conflict");
    chk("conflict_pulse", 128'(wr_conflict), 128'(1));
    idle();
    tick("conflict_after");
    chk("conflict_reg5", 128'(rd_data[DW-1:0]), 128'(32'h22));
    chk("conflict_clear", 128'(wr_conflict), 128'(0));

    // Scoreboard: alloc, retire, alloc+write together
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick("alloc7");
    chk("alloc7_busy", 128'(busy_vec[7]), 128'(1));
    alloc_en = 1'b1;  // re-alloc of a busy register stays busy
    tick("realloc7");
    chk("realloc7_busy", 128'(busy_vec[7]), 128'(1));
    idle();
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77;
    tick("retire7");
    chk("retire7_busy", 128'(busy_vec[7]), 128'(0));
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h33;
    tick("alloc_wr7");
    idle();
    rd_addr = raddr(0, 0, 0, 7);
    tick("read7");
    chk("alloc_wr7_busy", 128'(busy_vec[7]), 128'(1));
    chk("alloc_wr7_data", 128'(rd_data[DW-1:0]), 128'(32'h33));
    chk("alloc_wr7_rbusy", 128'(rd_busy[0]), 128'(1));

    // Same-cycle write/read of register 9
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
    tick("pre9");
    idle();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5_A5A5;
    rd_addr = raddr(0, 0, 0, 9);
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("byp9_same", 128'(rd_data[DW-1:0]), 128'(32'hA5A5_A5A5));
`else
    chk("byp9_same", 128'(rd_data[DW-1:0]), 128'(32'h1234));
`endif
    tick("byp9");
    idle();
    tick("byp9_next");
    chk("byp9_next", 128'(rd_data[DW-1:0]), 128'(32'hA5A5_A5A5));

    // Four read ports, distinct registers
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'd1;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'd2;
    tick("load12");
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd3;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'd4;
    tick("load34");
    idle();
    rd_addr = raddr(4, 3, 2, 1);
    tick("read4");
    chk("read4_pack", 128'(rd_data), {32'd4, 32'd3, 32'd2, 32'd1});

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      we0        = 1'($urandom);
      we1        = 1'($urandom);
      wa0        = 5'($urandom);
      wa1        = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
      wd0        = $urandom;
      wd1        = $urandom;
      alloc_en   = 1'($urandom);
      alloc_addr = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
      rd_addr    = raddr(($urandom_range(0, 1) == 0) ? int'(wa1) : int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)),
                         int'(alloc_addr),
                         ($urandom_range(0, 1) == 0) ? int'(wa0) : int'($urandom_range(0, 31)));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
